// File: rtl/csr_access_ctrl.sv
// Initiator side of the machine-mode CSR file interface: sequences Zicsr
// read-modify-write, ECALL trap entry and MRET return, one request at a time.
module csr_access_ctrl #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_sys,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_rs1_data,
  input  logic [4:0]        req_rs1_idx,
  input  logic [XLEN-1:0]   req_pc,
  output logic [ADDR_W-1:0] csr_addr,
  output logic [XLEN-1:0]   csr_wdata,
  output logic              csr_we,
  output logic              csr_is_ecall,
  output logic [XLEN-1:0]   csr_pc,
  input  logic [XLEN-1:0]   csr_rdata,
  input  logic [XLEN-1:0]   csr_mtvec,
  input  logic [XLEN-1:0]   csr_mepc,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rd_data,
  output logic              rsp_redirect,
  output logic [XLEN-1:0]   rsp_redirect_pc,
  output logic              rsp_illegal
);

  localparam logic [1:0] SYS_CSR   = 2'b00;
  localparam logic [1:0] SYS_ECALL = 2'b01;
  localparam logic [1:0] SYS_MRET  = 2'b10;
  localparam logic [1:0] SYS_ILL   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WRITE, S_TRAP, S_VEC, S_RESP
  } state_t;

  state_t state_q, state_d;

  logic [1:0]        sys_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   rs1_data_q;
  logic [4:0]        rs1_idx_q;
  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   old_q;
  logic [XLEN-1:0]   redirect_pc_q;
  logic              illegal_q;

  logic              accept;
  logic              req_illegal;
  logic [XLEN-1:0]   src;
  logic [XLEN-1:0]   new_val;
  logic              write_en;

  assign accept      = req_valid && (state_q == S_IDLE);
  // funct3 values 000 and 100 are the only undefined Zicsr encodings
  assign req_illegal = (req_sys == SYS_ILL) ||
                       ((req_sys == SYS_CSR) && (req_funct3[1:0] == 2'b00));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_illegal)                state_d = S_RESP;
          else if (req_sys == SYS_ECALL)  state_d = S_TRAP;
          else if (req_sys == SYS_MRET)   state_d = S_RESP;
          else                            state_d = S_READ;
        end
      end
      S_READ:  state_d = S_WRITE;
      S_WRITE: state_d = S_RESP;
      S_TRAP:  state_d = S_VEC;
      S_VEC:   state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request fields, old CSR value and redirect target
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sys_q         <= '0;
      funct3_q      <= '0;
      addr_q        <= '0;
      rs1_data_q    <= '0;
      rs1_idx_q     <= '0;
      pc_q          <= '0;
      old_q         <= '0;
      redirect_pc_q <= '0;
      illegal_q     <= 1'b0;
    end else begin
      if (accept) begin
        sys_q         <= req_sys;
        funct3_q      <= req_funct3;
        addr_q        <= req_addr;
        rs1_data_q    <= req_rs1_data;
        rs1_idx_q     <= req_rs1_idx;
        pc_q          <= req_pc;
        old_q         <= '0;
        illegal_q     <= req_illegal;
        redirect_pc_q <= (req_sys == SYS_MRET) ? csr_mepc : '0;
      end
      if (state_q == S_READ) old_q         <= csr_rdata;
      if (state_q == S_VEC)  redirect_pc_q <= csr_mtvec;
    end
  end

  // Read-modify-write datapath; set/clear with x0/zimm=0 must not write
  always_comb begin
    src = funct3_q[2] ? XLEN'(rs1_idx_q) : rs1_data_q;
    case (funct3_q[1:0])
      2'b01:   new_val = src;
      2'b10:   new_val = old_q | src;
      default: new_val = old_q & ~src;
    endcase
    write_en = (funct3_q[1:0] == 2'b01) || (rs1_idx_q != 5'd0);
  end

  // Output decode
  always_comb begin
    req_ready       = 1'b0;
    csr_addr        = '0;
    csr_wdata       = '0;
    csr_we          = 1'b0;
    csr_is_ecall    = 1'b0;
    csr_pc          = '0;
    rsp_valid       = 1'b0;
    rsp_rd_data     = '0;
    rsp_redirect    = 1'b0;
    rsp_redirect_pc = '0;
    rsp_illegal     = 1'b0;
    case (state_q)
      S_IDLE:  req_ready = 1'b1;
      S_READ:  csr_addr  = addr_q;
      S_WRITE: begin
        csr_addr  = addr_q;
        csr_we    = write_en;
        csr_wdata = write_en ? new_val : '0;
      end
      S_TRAP: begin
        csr_is_ecall = 1'b1;
        csr_pc       = pc_q;
      end
      S_RESP: begin
        rsp_valid       = 1'b1;
        rsp_rd_data     = old_q;
        rsp_redirect    = !illegal_q && ((sys_q == SYS_ECALL) || (sys_q == SYS_MRET));
        rsp_redirect_pc = redirect_pc_q;
        rsp_illegal     = illegal_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Randomized self-checking bench for csr_access_ctrl with a transaction-level
// reference model of the CSR file, mepc and the expected response.
module tb_csr_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_sys;
  logic [2:0]  req_funct3;
  logic [11:0] req_addr;
  logic [31:0] req_rs1_data;
  logic [4:0]  req_rs1_idx;
  logic [31:0] req_pc;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        csr_we;
  logic        csr_is_ecall;
  logic [31:0] csr_pc;
  logic [31:0] csr_rdata;
  logic [31:0] csr_mtvec;
  logic [31:0] csr_mepc;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rd_data;
  logic        rsp_redirect;
  logic [31:0] rsp_redirect_pc;
  logic        rsp_illegal;

  int n_checks = 0;
  int n_errors = 0;

  csr_access_ctrl #(.XLEN(32), .ADDR_W(12)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_sys(req_sys),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_rs1_data(req_rs1_data),
    .req_rs1_idx(req_rs1_idx), .req_pc(req_pc),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_we(csr_we),
    .csr_is_ecall(csr_is_ecall), .csr_pc(csr_pc), .csr_rdata(csr_rdata),
    .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd_data(rsp_rd_data),
    .rsp_redirect(rsp_redirect), .rsp_redirect_pc(rsp_redirect_pc),
    .rsp_illegal(rsp_illegal)
  );

  always #5 clk = ~clk;

  // Environment CSR file, updated only by DUT strobes or a preload request
  logic [31:0] csr_file [0:4095];
  logic [31:0] env_mepc = '0;
  logic [31:0] mtvec_v  = '0;
  logic        preload_req = 1'b0;
  logic [11:0] preload_addr = '0;
  logic [31:0] preload_val = '0;
  int          we_total = 0;
  int          ecall_total = 0;
  logic [31:0] wdata_seen = '0;
  logic [31:0] pc_seen = '0;

  assign csr_rdata = csr_file[csr_addr];
  assign csr_mtvec = mtvec_v;
  assign csr_mepc  = env_mepc;

  always @(posedge clk) begin
    if (csr_we)            csr_file[csr_addr] <= csr_wdata;
    else if (preload_req)  csr_file[preload_addr] <= preload_val;
    if (csr_is_ecall)      env_mepc <= csr_pc;
  end

  always @(negedge clk) begin
    if (csr_we)       begin we_total++;    wdata_seen = csr_wdata; end
    if (csr_is_ecall) begin ecall_total++; pc_seen    = csr_pc;    end
  end

  // Reference model state
  logic [31:0] ref_csr [0:4095];
  logic [31:0] ref_mepc = '0;

  typedef struct {
    logic [31:0] rd;
    logic [31:0] redir;
    logic [31:0] rpc;
    logic [31:0] ill;
    logic [31:0] lat;
    logic [31:0] we;
    logic [31:0] wdata;
    logic [31:0] ecall;
  } exp_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Architectural effect of one instruction, straight from the Zicsr rules
  task automatic ref_exec(input logic [1:0] sys, input logic [2:0] f3, input logic [11:0] addr,
                          input logic [31:0] rs1, input logic [4:0] idx, input logic [31:0] pc,
                          output exp_t e);
    logic [31:0] old, src, nv;
    e = '{default: '0};
    e.lat = 0;
    if (sys == 2'b01) begin
      e.redir = 1; e.rpc = mtvec_v; e.ecall = 1; e.lat = 2;
      ref_mepc = pc;
    end else if (sys == 2'b10) begin
      e.redir = 1; e.rpc = ref_mepc;
    end else if (sys == 2'b11 || f3 == 3'd0 || f3 == 3'd4) begin
      e.ill = 1;
    end else begin
      old = ref_csr[addr];
      src = (f3 >= 3'd5) ? {27'd0, idx} : rs1;
      case (f3)
        3'd1, 3'd5: nv = src;
        3'd2, 3'd6: nv = old | src;
        default:    nv = old & ~src;
      endcase
      e.rd = old; e.lat = 2;
      if (f3 == 3'd1 || f3 == 3'd5 || idx != 5'd0) begin
        e.we = 1; e.wdata = nv; ref_csr[addr] = nv;
      end
    end
  endtask

  task automatic preload(input logic [11:0] addr, input logic [31:0] val);
    preload_addr = addr; preload_val = val; preload_req = 1'b1;
    @(posedge clk); #1;
    preload_req = 1'b0;
    ref_csr[addr] = val;
  endtask

  task automatic scramble_req();
    req_sys = 2'($urandom); req_funct3 = 3'($urandom); req_addr = 12'($urandom);
    req_rs1_data = $urandom; req_rs1_idx = 5'($urandom); req_pc = $urandom;
  endtask

  task automatic do_txn(input logic [1:0] sys, input logic [2:0] f3, input logic [11:0] addr,
                        input logic [31:0] rs1, input logic [4:0] idx, input logic [31:0] pc,
                        input int stall);
    exp_t e;
    int cyc, we0, ec0;
    ref_exec(sys, f3, addr, rs1, idx, pc, e);
    we0 = we_total; ec0 = ecall_total;
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_sys = sys; req_funct3 = f3; req_addr = addr;
    req_rs1_data = rs1; req_rs1_idx = idx; req_pc = pc;
    @(posedge clk); #1;
    req_valid = 1'b0;
    scramble_req();
    cyc = 0;
    while (!rsp_valid && cyc < 8) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", 32'(cyc), e.lat);
    check("rd_data", rsp_rd_data, e.rd);
    check("redirect", 32'(rsp_redirect), e.redir);
    check("redirect_pc", rsp_redirect_pc, e.rpc);
    check("illegal", 32'(rsp_illegal), e.ill);
    for (int i = 0; i < stall; i++) begin
      req_valid = 1'b1;
      @(posedge clk); #1;
      check("stall_valid", 32'(rsp_valid), 32'd1);
      check("stall_rd_data", rsp_rd_data, e.rd);
      check("stall_redirect_pc", rsp_redirect_pc, e.rpc);
      check("no_accept", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("rsp_drop", 32'(rsp_valid), 32'd0);
    check("ready_back", 32'(req_ready), 32'd1);
    check("idle_bus", 32'(csr_addr) | csr_wdata | csr_pc, 32'd0);
    check("we_count", 32'(we_total - we0), e.we);
    if (e.we != 0) check("wdata", wdata_seen, e.wdata);
    check("ecall_count", 32'(ecall_total - ec0), e.ecall);
    if (e.ecall != 0) begin
      check("trap_pc", pc_seen, pc);
      check("mepc", env_mepc, ref_mepc);
    end
    if (e.lat == 2 && e.ecall == 0) check("csr_value", csr_file[addr], ref_csr[addr]);
  endtask

  task automatic reset_mid_write();
    int we0;
    we0 = we_total;
    req_valid = 1'b1; req_sys = 2'b00; req_funct3 = 3'd1; req_addr = 12'h300;
    req_rs1_data = 32'hDEAD_BEEF; req_rs1_idx = 5'd3; req_pc = 32'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #2;
    check("write_state_we", 32'(csr_we), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_we_drop", 32'(csr_we), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_bus", 32'(csr_addr) | csr_wdata | rsp_rd_data, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", 32'(req_ready), 32'd1);
    check("post_rst_we", 32'(we_total - we0), 32'd0);
    check("rst_csr_unchanged", csr_file[12'h300], ref_csr[12'h300]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got 0x%08h expected 0x%08h", 32'd1, 32'd0);
    $fatal(1, "bench timeout");
  end

  logic [11:0] addr_pool [4];

  initial begin
    addr_pool[0] = 12'h300; addr_pool[1] = 12'h305;
    addr_pool[2] = 12'h340; addr_pool[3] = 12'h342;
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_sys = '0; req_funct3 = '0; req_addr = '0; req_rs1_data = '0;
    req_rs1_idx = '0; req_pc = '0;
    @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_strobes", 32'({csr_we, csr_is_ecall}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    preload(12'h300, 32'h0000_1800);
    preload(12'h305, 32'h0);
    preload(12'h340, 32'h0);
    preload(12'h342, 32'h0);

    do_txn(2'b00, 3'b010, 12'h300, 32'h0, 5'd0, 32'h8000_0000, 0);
    check("mstatus_read", csr_file[12'h300], 32'h0000_1800);
    do_txn(2'b00, 3'b001, 12'h305, 32'h8000_0100, 5'd1, 32'h8000_0004, 0);
    do_txn(2'b00, 3'b010, 12'h305, 32'h0, 5'd5, 32'h8000_0008, 0);
    check("mtvec_written", csr_file[12'h305], 32'h8000_0100);
    preload(12'h300, 32'h0000_180F);
    do_txn(2'b00, 3'b111, 12'h300, 32'h0, 5'h08, 32'h8000_000C, 0);
    check("rci_result", csr_file[12'h300], 32'h0000_1807);
    mtvec_v = 32'h8000_0100;
    do_txn(2'b01, 3'b000, 12'h000, 32'h0, 5'd0, 32'h8000_0040, 0);
    do_txn(2'b10, 3'b000, 12'h000, 32'h0, 5'd0, 32'h8000_0100, 5);
    do_txn(2'b00, 3'b100, 12'h300, 32'hFFFF_FFFF, 5'd7, 32'h8000_0044, 5);
    do_txn(2'b11, 3'b001, 12'h300, 32'hFFFF_FFFF, 5'd7, 32'h8000_0048, 1);
    reset_mid_write();

    for (int n = 0; n < 200; n++) begin
      logic [1:0] s;
      int pick;
      pick = int'($urandom_range(0, 9));
      s = (pick < 7) ? 2'b00 : 2'(pick - 6);
      mtvec_v = $urandom & 32'hFFFF_FFFC;
      do_txn(s, 3'($urandom), addr_pool[$urandom_range(0, 3)], $urandom,
             ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
             $urandom & 32'hFFFF_FFFC, int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/csr_access_ctrl.md
Name: csr_access_ctrl

Overview:
- Initiator side of the machine-mode CSR register file interface.
- Accepts one decoded Zicsr/system request at a time from the decode stage: CSRRW/S/C and their immediate forms, ECALL, MRET.
- Sequences the read-modify-write, or the trap entry/return, against the CSR file.
- Returns the old CSR value and any PC redirect to writeback through a valid/ready response port.

Parameters:
- XLEN, 32, data/PC width
- ADDR_W, 12, CSR address width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept; high only in IDLE
- req_sys  in  2  00 CSR op, 01 ECALL, 10 MRET, 11 illegal
- req_funct3  in  3  001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
- req_addr  in  ADDR_W  CSR address
- req_rs1_data  in  XLEN  rs1 value
- req_rs1_idx  in  5  rs1 index; for I-forms this is zimm
- req_pc  in  XLEN  PC of the instruction
- csr_addr  out  ADDR_W  CSR address to the file
- csr_wdata  out  XLEN  write data
- csr_we  out  1  write strobe, one cycle
- csr_is_ecall  out  1  trap strobe, one cycle
- csr_pc  out  XLEN  PC saved into mepc on trap
- csr_rdata  in  XLEN  combinational read data for csr_addr
- csr_mtvec  in  XLEN  current mtvec
- csr_mepc  in  XLEN  current mepc
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts
- rsp_rd_data  out  XLEN  old CSR value; 0 for ECALL/MRET/illegal
- rsp_redirect  out  1  PC must be redirected
- rsp_redirect_pc  out  XLEN  redirect target
- rsp_illegal  out  1  request was illegal

Behaviour:
- Reset (async, any state, including mid-operation):
  - State returns to IDLE and all latched fields clear.
  - No csr_we or csr_is_ecall is issued for an aborted request.
  - Outputs during/after reset: req_ready=1 (IDLE), all other outputs 0.
- States: IDLE, READ, WRITE, TRAP, VEC, RESP.
- Accept: edge where req_valid & req_ready. All req_* fields are latched at that edge; later input changes are ignored.
- IDLE exits at the accept edge:
  - to READ for CSR op with legal funct3;
  - to TRAP for ECALL;
  - to RESP for MRET, which latches csr_mepc into redirect_pc;
  - to RESP for illegal, with rsp_illegal=1. Illegal means req_sys=11, or req_sys=00 with funct3 000 or 100.
- READ (1 cycle):
  - csr_addr = latched addr.
  - csr_rdata is captured as old value at exit.
  - Next state WRITE.
- WRITE (1 cycle):
  - csr_addr held; src = rs1_data, or {27'b0, zimm} for I-forms.
  - new = src (RW/RWI), old|src (RS/RSI), old&~src (RC/RCI).
  - csr_we=1 unless the op is RS/RC/RSI/RCI with rs1_idx==0; RW/RWI always write.
  - csr_wdata = new when csr_we=1, else 0.
  - Next state RESP.
- TRAP (1 cycle):
  - csr_is_ecall=1, csr_pc = latched pc.
  - Next state VEC.
- VEC (1 cycle):
  - csr_mtvec is captured into redirect_pc.
  - Next state RESP.
- RESP:
  - rsp_valid=1; all rsp_* fields are registered and stable while rsp_valid & !rsp_ready.
  - Goes to IDLE on the edge with rsp_ready=1.
  - rsp_redirect=1 for ECALL and MRET only.
- Latency from accept edge E0 to rsp_valid:
  - CSR op: rsp_valid from E2 (READ E0–E1, WRITE E1–E2).
  - ECALL: from E2.
  - MRET and illegal: from E1.
- Throughput:
  - No accept while RESP is pending; req_ready rises the cycle after the response handshake.
  - Minimum 4 cycles per CSR op when rsp_ready is held high.
- Idle outputs: csr_addr=0, csr_wdata=0, csr_pc=0, and csr_we/csr_is_ecall never high outside WRITE/TRAP.
- Wrap-around: none. All arithmetic is bitwise; no carry.

Test Plan:
- Reset, CSR model mstatus(0x300)=0x00001800. CSRRS addr 0x300, rs1_idx=0 -> rsp_rd_data=0x00001800, csr_we never asserted, rsp_valid 2 cycles after accept.
- CSRRW 0x305 rs1_data=0x80000100, then CSRRS 0x305 rs1_data=0 rs1_idx=5 -> csr_we one cycle with wdata 0x80000100; second rsp_rd_data=0x80000100, wdata=0x80000100.
- CSRRCI 0x300 zimm=0x08 with mstatus=0x0000180F -> csr_wdata=0x00001807, rsp_rd_data=0x0000180F.
- ECALL pc=0x80000040, mtvec=0x80000100 -> csr_is_ecall one cycle with csr_pc=0x80000040; rsp_redirect=1, redirect_pc=0x80000100, rd_data=0. Then MRET with mepc=0x80000040 -> redirect_pc=0x80000040 at E1.
- rsp_ready held 0 for 5 cycles -> rsp_* stable, req_ready=0 with req_valid=1 (no accept). funct3=100 -> rsp_illegal=1, no CSR strobe.
- rst asserted asynchronously mid-WRITE state -> csr_we drops immediately, state IDLE, req_ready=1 after release, CSR value unchanged.
